// File: rtl/flash_erase_seq.sv
// flash_erase_seq: owns the SPI flash pins and runs a complete erase from one request.
// Sequence: Write Enable (0x06), erase command, then Read Status (0x05) polling until WIP
// clears or the poll budget runs out. One done pulse per operation, with err flagging
// a timeout or a reserved opcode.
`timescale 1ns/1ps
module flash_erase_seq #(
    parameter int unsigned CS_SETUP = 8,
    parameter int unsigned CS_HOLD  = 8,
    parameter int unsigned CS_GAP   = 32,
    parameter int unsigned POLL_MAX = 20000000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [23:0] addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        sck,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);

    localparam int unsigned CntW  = 16;
    localparam int unsigned PollW = 25;

    localparam logic [CntW-1:0]  SetupLast = CntW'(CS_SETUP - 1);
    localparam logic [CntW-1:0]  HoldLast  = CntW'(CS_HOLD - 1);
    localparam logic [CntW-1:0]  GapLast   = CntW'(CS_GAP - 1);
    localparam logic [PollW-1:0] PollLimit = PollW'(POLL_MAX);

    localparam logic [7:0] OpWren = 8'h06;
    localparam logic [7:0] OpSe   = 8'hD8;
    localparam logic [7:0] OpBe   = 8'hC7;
    localparam logic [7:0] OpSse  = 8'h20;
    localparam logic [7:0] OpRdsr = 8'h05;

    // StBad covers the reserved opcode: one busy cycle, then an error done.
    typedef enum logic [2:0] {
        StIdle,
        StBad,
        StSetup,
        StBits,
        StHold,
        StGap,
        StDone
    } state_e;

    // Which transaction of the erase sequence is currently on the wire.
    typedef enum logic [1:0] {
        TxWren,
        TxCmd,
        TxPoll
    } tx_e;

    state_e            state_q, state_d;
    tx_e               tx_q, tx_d;
    logic [1:0]        op_q, op_d;
    logic [23:0]       addr_q, addr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        phase_q, phase_d;
    logic [4:0]        bit_q, bit_d;
    logic [31:0]       shift_q, shift_d;
    logic [7:0]        status_q, status_d;
    logic [PollW-1:0]  poll_q, poll_d;
    logic              err_flag_q, err_flag_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              sck_q, sck_d;
    logic              cs_n_q, cs_n_d;
    logic              mosi_q, mosi_d;

    logic [4:0]        last_bit;
    logic [31:0]       cmd_word;
    logic              wr_d;

    // Erase command frame for the latched op; bulk erase carries no address.
    always_comb begin
        unique case (op_q)
            2'b00:   cmd_word = {OpSe, addr_q};
            2'b10:   cmd_word = {OpSse, addr_q};
            default: cmd_word = {OpBe, 24'h000000};
        endcase
    end

    // Index of the final bit of the current transaction.
    always_comb begin
        unique case (tx_q)
            TxWren:  last_bit = 5'd7;
            TxCmd:   last_bit = (op_q == 2'b01) ? 5'd7 : 5'd31;
            default: last_bit = 5'd15;
        endcase
    end

    // State register plus datapath and pin registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= StIdle;
            tx_q       <= TxWren;
            op_q       <= 2'b00;
            addr_q     <= 24'h000000;
            cnt_q      <= '0;
            phase_q    <= 2'd0;
            bit_q      <= 5'd0;
            shift_q    <= 32'h0;
            status_q   <= 8'h00;
            poll_q     <= '0;
            err_flag_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            status_q   <= status_d;
            poll_q     <= poll_d;
            err_flag_q <= err_flag_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
        end
    end

    // Next-state and datapath: transaction framing, bit engine and poll decisions.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        op_d       = op_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        status_d   = status_q;
        poll_d     = poll_q;
        err_flag_d = err_flag_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    op_d       = op;
                    addr_d     = addr;
                    poll_d     = '0;
                    err_flag_d = 1'b0;
                    cnt_d      = '0;
                    if (op == 2'b11) begin
                        state_d = StBad;
                    end else begin
                        state_d = StSetup;
                        tx_d    = TxWren;
                        shift_d = {OpWren, 24'h000000};
                    end
                end
            end
            StBad: begin
                err_flag_d = 1'b1;
                state_d    = StDone;
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    cnt_d   = '0;
                    phase_d = 2'd0;
                    bit_d   = 5'd0;
                    state_d = StBits;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBits: begin
                phase_d = phase_q + 2'd1;
                // Capture on the edge that raises sck; flash shifted it out on the fall.
                if (phase_q == 2'd2 && tx_q == TxPoll) begin
                    status_d = {status_q[6:0], miso};
                end
                if (phase_q == 2'd3) begin
                    if (bit_q == last_bit) begin
                        cnt_d   = '0;
                        state_d = StHold;
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        shift_d = {shift_q[30:0], 1'b0};
                    end
                end
            end
            StHold: begin
                if (cnt_q == HoldLast) begin
                    cnt_d   = '0;
                    state_d = StGap;
                    if (tx_q == TxPoll) begin
                        poll_d = poll_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                // The gap follows every transaction, so back-to-back operations keep it too.
                if (cnt_q == GapLast) begin
                    cnt_d = '0;
                    unique case (tx_q)
                        TxWren: begin
                            tx_d    = TxCmd;
                            shift_d = cmd_word;
                            state_d = StSetup;
                        end
                        TxCmd: begin
                            tx_d    = TxPoll;
                            shift_d = {OpRdsr, 24'h000000};
                            state_d = StSetup;
                        end
                        default: begin
                            if (!status_q[0]) begin
                                state_d = StDone;
                            end else if (poll_q == PollLimit) begin
                                err_flag_d = 1'b1;
                                state_d    = StDone;
                            end else begin
                                shift_d = {OpRdsr, 24'h000000};
                                state_d = StSetup;
                            end
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from the next state so the pins come straight off flops.
    always_comb begin
        wr_d   = (tx_d != TxPoll) || (bit_d < 5'd8);
        busy_d = state_d inside {StBad, StSetup, StBits, StHold, StGap};
        done_d = (state_d == StDone);
        err_d  = (state_d == StDone) && err_flag_d;
        cs_n_d = !(state_d inside {StSetup, StBits, StHold});
        sck_d  = (state_d == StBits) && phase_d[1];
        mosi_d = (state_d == StBits) && wr_d && shift_d[31];
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign sck  = sck_q;
    assign cs_n = cs_n_q;
    assign mosi = mosi_q;

endmodule

// File: tb/tb_flash_erase_seq.sv
// Bench for flash_erase_seq: a waveform model built from the transaction rules is compared
// against the pins every cycle, and a flash/monitor model checks bytes, windows and gaps.
`timescale 1ns/1ps
module tb_flash_erase_seq;

    localparam int unsigned CsSetup = 8;
    localparam int unsigned CsHold  = 8;
    localparam int unsigned CsGap   = 32;
    localparam int unsigned PollMax = 5;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [23:0] addr = 24'h0;
    logic        busy, done, err, sck, cs_n, mosi;
    logic        miso = 1'b0;

    flash_erase_seq #(
        .CS_SETUP (CsSetup),
        .CS_HOLD  (CsHold),
        .CS_GAP   (CsGap),
        .POLL_MAX (PollMax)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req       (req),
        .op        (op),
        .addr      (addr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sck       (sck),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Expected per-cycle pins {busy,done,err,cs_n,sck,mosi}
    logic [5:0] exp_q[$];
    int         rd_idx  = 0;
    int         skip_to = 0;

    // Flash scenario: first nbusy polls return busy_val, later ones 0x00
    int         nbusy      = 0;
    logic [7:0] busy_val   = 8'h00;
    int         poll_base  = 0;

    // Monitor state
    logic       prev_cs  = 1'b1;
    logic       prev_sck = 1'b0;
    int         low_run = 0, high_run = 0, win_rises = 0, nb = 0, win_bytes = 0;
    logic [7:0] acc = 8'h00, win_op = 8'h00;
    int         falls = 0, polls_seen = 0, done_cnt = 0, rises_total = 0;
    logic       last_err = 1'b0;
    logic [7:0] byte_log[$];
    int         win_log[$];
    int         gap_log[$];

    int         b0, w0, g0, f0, d0, pb, r0, mg;
    logic [7:0] eb[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic push(input logic [5:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // One transaction: setup, bits (4 clocks each, sck high in the last two), hold, gap
    task automatic push_tx(input logic [31:0] data, input int nbits, input int nwrite);
        logic b;
        push(6'b100000, CsSetup);
        for (int i = 0; i < nbits; i++) begin
            b = (i < nwrite) ? data[31-i] : 1'b0;
            push({5'b10000, b}, 2);
            push({5'b10001, b}, 2);
        end
        push(6'b100000, CsHold);
        push(6'b100100, CsGap);
    endtask

    task automatic build_op(input logic [1:0] o, input logic [23:0] a, input int nbz);
        int npoll;
        if (o == 2'b11) begin
            push(6'b100100, 1);
            push(6'b011100, 1);
        end else begin
            push_tx(32'h0600_0000, 8, 8);
            if (o == 2'b00)      push_tx({8'hD8, a}, 32, 32);
            else if (o == 2'b01) push_tx(32'hC700_0000, 8, 8);
            else                 push_tx({8'h20, a}, 32, 32);
            npoll = (nbz + 1 < int'(PollMax)) ? nbz + 1 : int'(PollMax);
            for (int i = 0; i < npoll; i++) push_tx(32'h0500_0000, 16, 8);
            push({2'b01, (nbz >= int'(PollMax)), 3'b100}, 1);
        end
        push(6'b000100, 2);
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge sys_clk);
            if (rd_idx < skip_to) rd_idx = skip_to;
            if (rd_idx < exp_q.size()) begin
                check($sformatf("pins{busy,done,err,cs_n,sck,mosi} at model step %0d", rd_idx),
                      32'({busy, done, err, cs_n, sck, mosi}), 32'(exp_q[rd_idx]));
                rd_idx++;
            end
        end
    endtask

    // Flash behaviour plus pin monitor; miso changes only while sck is low
    task automatic monitor_loop();
        logic [7:0] cur;
        forever begin
            @(negedge sys_clk);
            if (!cs_n) begin
                if (prev_cs) begin
                    falls++;
                    gap_log.push_back(high_run);
                    low_run = 0; win_rises = 0; nb = 0; win_bytes = 0; win_op = 8'h00;
                end
                low_run++;
                if (sck && !prev_sck) begin
                    win_rises++; rises_total++;
                    acc = {acc[6:0], mosi};
                    nb++;
                    if (nb == 8) begin
                        if (win_bytes == 0) win_op = acc;
                        if (win_bytes == 0 || win_op != 8'h05) byte_log.push_back(acc);
                        win_bytes++;
                        nb = 0;
                    end
                end
                if (!sck && prev_sck) begin
                    cur = ((polls_seen - poll_base) < nbusy) ? busy_val : 8'h00;
                    if (win_op == 8'h05 && win_rises >= 8 && win_rises < 16) miso = cur[15-win_rises];
                    else miso = 1'b0;
                end
            end else begin
                if (!prev_cs) begin
                    win_log.push_back(low_run);
                    if (win_op == 8'h05 && win_rises == 16) polls_seen++;
                    high_run = 0;
                end
                miso = 1'b0;
                high_run++;
            end
            if (done) begin
                done_cnt++;
                last_err = err;
            end
            prev_cs  = cs_n;
            prev_sck = sck;
        end
    endtask

    task automatic snap();
        b0 = byte_log.size(); w0 = win_log.size(); g0 = gap_log.size();
        f0 = falls; d0 = done_cnt; pb = polls_seen; r0 = rises_total;
    endtask

    task automatic start_op(input logic [1:0] o, input logic [23:0] a, input int nbz,
                            input logic [7:0] bv);
        @(posedge sys_clk); #1;
        nbusy = nbz; busy_val = bv; poll_base = polls_seen;
        snap();
        req = 1'b1; op = o; addr = a;
        @(posedge sys_clk); #1;
        req = 1'b0;
        build_op(o, a, nbz);
    endtask

    task automatic wait_drain();
        int n = 0;
        int lim = exp_q.size() - rd_idx + 20;
        while (rd_idx < exp_q.size() && n < lim) begin
            @(negedge sys_clk); #1;
            n++;
        end
    endtask

    task automatic wait_rises(input int target, input string nm);
        int n = 0;
        while (rises_total < target && n < 5000) begin
            @(negedge sys_clk); #1;
            n++;
        end
        check({nm, " sck rise reached"}, 32'(rises_total >= target), 32'd1);
    endtask

    task automatic check_bytes(input string nm, input logic [7:0] e[$]);
        check({nm, " byte count"}, 32'(byte_log.size() - b0), 32'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            if (b0 + i < byte_log.size())
                check($sformatf("%s byte %0d", nm, i), 32'(byte_log[b0+i]), 32'(e[i]));
            else
                check($sformatf("%s byte %0d absent", nm, i), 32'hFFFF_FFFF, 32'(e[i]));
        end
    endtask

    initial begin
        fork
            compare_loop();
            monitor_loop();
        join_none

        // Reset values
        #12;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst err",  32'(err),  32'd0);
        check("rst sck",  32'(sck),  32'd0);
        check("rst cs_n", 32'(cs_n), 32'd1);
        check("rst mosi", 32'(mosi), 32'd0);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        // Bulk erase, three busy polls then ready
        start_op(2'b01, 24'h000000, 3, 8'h03);
        wait_drain();
        eb = '{8'h06, 8'hC7, 8'h05, 8'h05, 8'h05, 8'h05};
        check_bytes("be", eb);
        check("be cs_n falls", 32'(falls - f0), 32'd6);
        check("be polls", 32'(polls_seen - pb), 32'd4);
        check("be wren window", 32'((win_log.size() > w0) ? win_log[w0] : -1), 32'd48);
        mg = 1000000;
        for (int i = g0 + 1; i < gap_log.size(); i++) if (gap_log[i] < mg) mg = gap_log[i];
        check("be min gap>=32", 32'(mg >= 32), 32'd1);
        check("be done count", 32'(done_cnt - d0), 32'd1);
        check("be err", 32'(last_err), 32'd0);

        // Sector erase, ready on first poll
        start_op(2'b00, 24'h123456, 0, 8'h01);
        wait_drain();
        eb = '{8'h06, 8'hD8, 8'h12, 8'h34, 8'h56, 8'h05};
        check_bytes("se", eb);
        check("se cmd window", 32'((win_log.size() > w0 + 1) ? win_log[w0+1] : -1), 32'd144);
        check("se cs_n falls", 32'(falls - f0), 32'd3);
        check("se done count", 32'(done_cnt - d0), 32'd1);
        check("se err", 32'(last_err), 32'd0);

        // Reserved op
        start_op(2'b11, 24'hFFFFFF, 0, 8'h00);
        wait_drain();
        check("bad cs_n falls", 32'(falls - f0), 32'd0);
        check("bad done count", 32'(done_cnt - d0), 32'd1);
        check("bad err", 32'(last_err), 32'd1);

        // Timeout: miso held high through every status read
        start_op(2'b01, 24'h000000, 1000, 8'hFF);
        wait_drain();
        repeat (100) @(negedge sys_clk);
        check("tmo cs_n falls", 32'(falls - f0), 32'd7);
        check("tmo polls", 32'(polls_seen - pb), 32'd5);
        check("tmo done count", 32'(done_cnt - d0), 32'd1);
        check("tmo err", 32'(last_err), 32'd1);

        // Second request mid-command is ignored
        start_op(2'b00, 24'hABCDEF, 1, 8'h01);
        wait_rises(r0 + 18, "ign");
        @(posedge sys_clk); #1;
        req = 1'b1; op = 2'b10; addr = 24'h000111;
        @(posedge sys_clk); #1;
        req = 1'b0; op = 2'b00;
        wait_drain();
        repeat (60) @(negedge sys_clk);
        eb = '{8'h06, 8'hD8, 8'hAB, 8'hCD, 8'hEF, 8'h05, 8'h05};
        check_bytes("ign", eb);
        check("ign cs_n falls", 32'(falls - f0), 32'd4);
        check("ign done count", 32'(done_cnt - d0), 32'd1);
        check("ign err", 32'(last_err), 32'd0);
        check("ign busy after", 32'(busy), 32'd0);

        // Reset during command bit 17, then a clean subsector erase
        start_op(2'b10, 24'h0F1E2D, 1, 8'h01);
        wait_rises(r0 + 26, "rst");
        #1;
        skip_to = exp_q.size();
        sys_rst_n = 1'b0;
        #1;
        check("async rst cs_n", 32'(cs_n), 32'd1);
        check("async rst sck",  32'(sck),  32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        repeat (3) @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("rst abandoned done count", 32'(done_cnt - d0), 32'd0);
        start_op(2'b10, 24'h0F1E2D, 1, 8'h01);
        wait_drain();
        eb = '{8'h06, 8'h20, 8'h0F, 8'h1E, 8'h2D, 8'h05, 8'h05};
        check_bytes("sse", eb);
        check("sse done count", 32'(done_cnt - d0), 32'd1);
        check("sse err", 32'(last_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
